// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying FIFO words from the read controller to a consumer.
interface fifo_rd_stream_if #(
    parameter int unsigned DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO controller: issues credit-limited reads, absorbs the FIFO read
// latency in a 2-entry buffer and presents the words as a valid/ready stream.
// RD_LAT must be 1 or 2; BUF_D must be 2.
module fifo_rd_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BUF_D  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_d_out,
    output logic              fifo_r_en,
    fifo_rd_stream_if.master  m,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              idle
);
    localparam int unsigned OCC_W = 2;
    localparam int unsigned INF_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [RD_LAT-1:0] infl_q, infl_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [INF_W-1:0]  infl_cnt_c;
    logic [SUM_W-1:0]  credit_c;
    logic              pop_c;
    logic              cap_c;

    // Number of reads issued to the FIFO whose data has not landed yet.
    always_comb begin
        infl_cnt_c = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            infl_cnt_c = infl_cnt_c + INF_W'(infl_q[i]);
        end
    end

    // Read only when the word is guaranteed a slot, counting this cycle's pop as freed.
    always_comb begin
        pop_c     = valid_q & m.ready;
        cap_c     = infl_q[RD_LAT-1];
        credit_c  = SUM_W'(occ_q) + SUM_W'(infl_cnt_c) - SUM_W'(pop_c);
        fifo_r_en = !rst && drain_en && !fifo_empty && (credit_c < SUM_W'(BUF_D));
    end

    // Next state of the read pipeline, output buffer and delivered-word counter.
    always_comb begin
        infl_d    = '0;
        infl_d[0] = fifo_r_en;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            infl_d[i] = infl_q[i-1];
        end

        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;

        unique case ({cap_c, pop_c})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = fifo_d_out;
                end else begin
                    tail_d = fifo_d_out;
                end
                occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - OCC_W'(1);
            end
            2'b11: begin
                // Occupancy is unchanged; the landing word joins behind whatever remains.
                if (occ_q == OCC_W'(1)) begin
                    head_d = fifo_d_out;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_d_out;
                end
            end
            default: begin
            end
        endcase

        valid_d = (occ_d != '0);
        cnt_d   = cnt_q + CNT_W'(pop_c);
    end

    // State registers; reset also flushes in-flight reads so late data is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl_q  <= '0;
            occ_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            infl_q  <= infl_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stream and status outputs.
    assign m.valid  = valid_q;
    assign m.data   = head_q;
    assign word_cnt = cnt_q;
    assign idle     = (occ_q == '0) && (infl_cnt_c == '0) && fifo_empty;

    // A landing word must always find a free buffer slot.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(cap_c && (occ_q == OCC_W'(BUF_D)) && !pop_c));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two DUTs (RD_LAT=1/CNT_W=16 and RD_LAT=2/CNT_W=4) share
// stimulus; each has its own FIFO model and an in-order expected-word scoreboard.
module tb_fifo_rd_stream;
    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_ready = 1'b0;
    logic [1:0] drain_en = 2'b00;
    int   cyc = 0;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] fq    [2][$];
    logic [DATA_W-1:0] exp_q [2][$];
    int reads[2], pops[2], delivered[2], out_cnt[2];
    int first_ren[2], first_val[2], first_pop[2], last_pop[2];

    logic [1:0]        ren_v, val_v, idle_v;
    logic [DATA_W-1:0] data_v [2];
    logic [15:0]       cnt_v  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Ideal pop spacing: two credits recirculate every RD_LAT+1 cycles.
    function automatic int span(input int lat, input int n);
        return (lat + 1) * ((n - 1) / 2) + (n - 1) % 2;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned LAT = g + 1;
        localparam int unsigned CW  = (g == 0) ? 16 : 4;

        fifo_rd_stream_if #(.DATA_W(DATA_W)) sif ();
        logic              fifo_empty = 1'b1;
        logic [DATA_W-1:0] fifo_d_out = '0;
        logic              fifo_r_en;
        logic              idle;
        logic [CW-1:0]     word_cnt;
        logic [DATA_W-1:0] dq [2] = '{8'h00, 8'h00};
        logic              ren_s = 1'b0;
        logic [DATA_W-1:0] e;
        logic              pop;

        assign sif.ready = m_ready;
        assign ren_v[g]  = fifo_r_en;
        assign val_v[g]  = sif.valid;
        assign idle_v[g] = idle;
        assign data_v[g] = sif.data;
        assign cnt_v[g]  = 16'(word_cnt);

        fifo_rd_stream #(.DATA_W(DATA_W), .RD_LAT(LAT), .BUF_D(2), .CNT_W(CW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .drain_en   (drain_en[g]),
            .fifo_empty (fifo_empty),
            .fifo_d_out (fifo_d_out),
            .fifo_r_en  (fifo_r_en),
            .m          (sif),
            .word_cnt   (word_cnt),
            .idle       (idle)
        );

        // FIFO model: a read committed at the last edge shows up LAT cycles after its strobe.
        always @(negedge clk) begin
            dq[1] = dq[0];
            if (ren_s) begin
                chk($sformatf("read_nonempty%0d", g), 32'(fq[g].size() != 0), 1);
                dq[0] = (fq[g].size() != 0) ? fq[g].pop_front() : '0;
            end else begin
                dq[0] = DATA_W'($urandom);
            end
            fifo_d_out = dq[LAT-1];
            fifo_empty = (fq[g].size() == 0);
        end

        // Read sampler: records strobes and checks words owed never exceed two.
        always @(negedge clk) begin
            #4;
            pop   = sif.valid && m_ready && !rst;
            ren_s = fifo_r_en;
            if (fifo_r_en) begin
                reads[g]++;
                if (first_ren[g] < 0) first_ren[g] = cyc;
                chk($sformatf("credit%0d", g), 32'((out_cnt[g] + 1 - int'(pop)) <= 2), 1);
            end
            out_cnt[g] = out_cnt[g] + int'(fifo_r_en) - int'(pop);
        end

        // Monitor: every accepted word must be the next expected one; stalled words hold.
        always @(negedge clk) begin
            #4;
            if (!rst && sif.valid) begin
                if (first_val[g] < 0) first_val[g] = cyc;
                if (exp_q[g].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word%0d: got 0x%0h expected none", g, sif.data);
                end else if (m_ready) begin
                    e = exp_q[g].pop_front();
                    chk($sformatf("data%0d", g), 32'(sif.data), 32'(e));
                    pops[g]++;
                    delivered[g]++;
                    if (first_pop[g] < 0) first_pop[g] = cyc;
                    last_pop[g] = cyc;
                end else begin
                    chk($sformatf("hold%0d", g), 32'(sif.data), 32'(exp_q[g][0]));
                end
            end
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] w);
        for (int g = 0; g < 2; g++) begin
            fq[g].push_back(w);
            exp_q[g].push_back(w);
        end
    endtask

    task automatic clear_stats();
        for (int g = 0; g < 2; g++) begin
            reads[g]     = 0;
            pops[g]      = 0;
            first_ren[g] = -1;
            first_val[g] = -1;
            first_pop[g] = -1;
            last_pop[g]  = -1;
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(idle_v == 2'b11 && exp_q[0].size() == 0 && exp_q[1].size() == 0) && n < budget) begin
            @(negedge clk);
            #4;
            n++;
        end
        chk({tag, "_drained"}, 32'(n < budget), 1);
        @(negedge clk);
    endtask

    // Reset mid-stream: undelivered words still in the FIFO become the new expectation.
    task automatic reset_pulse(input bit check);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        if (check) begin
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("rst_valid%0d", g), 32'(val_v[g]), 0);
                chk($sformatf("rst_cnt%0d", g), 32'(cnt_v[g]), 0);
                chk($sformatf("rst_ren%0d", g), 32'(ren_v[g]), 0);
            end
        end
        for (int g = 0; g < 2; g++) begin
            exp_q[g]     = fq[g];
            out_cnt[g]   = 0;
            delivered[g] = 0;
        end
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int pops_off[2], reads_off[2], fq_off[2], remain[2];
        logic [DATA_W-1:0] t1 [4] = '{8'h0F, 8'h09, 8'h07, 8'h21};

        for (int g = 0; g < 2; g++) begin
            out_cnt[g]   = 0;
            delivered[g] = 0;
        end
        clear_stats();

        // Reset state
        repeat (3) @(negedge clk);
        #4;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("init_valid%0d", g), 32'(val_v[g]), 0);
            chk($sformatf("init_data%0d", g), 32'(data_v[g]), 0);
            chk($sformatf("init_cnt%0d", g), 32'(cnt_v[g]), 0);
            chk($sformatf("init_idle%0d", g), 32'(idle_v[g]), 1);
        end
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);

        // 1: four-word burst with latency and back-to-back delivery
        clear_stats();
        drain_en = 2'b11;
        m_ready  = 1'b1;
        for (int i = 0; i < 4; i++) push_word(t1[i]);
        wait_idle(80, "t1");
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("t1_cnt%0d", g), 32'(cnt_v[g]), 4);
            chk($sformatf("t1_latency%0d", g), 32'(first_val[g] - first_ren[g]), 32'(g + 2));
            chk($sformatf("t1_span%0d", g), 32'(last_pop[g] - first_pop[g]), 32'(span(g + 1, 4)));
            chk($sformatf("t1_idle%0d", g), 32'(idle_v[g]), 1);
        end

        // 2: consumer stalled for 10 cycles with 16 words waiting
        clear_stats();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(DATA_W'($urandom));
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("t2_reads%0d", g), 32'(reads[g]), 2);
            chk($sformatf("t2_nopop%0d", g), 32'(pops[g]), 0);
        end
        m_ready = 1'b1;
        wait_idle(200, "t2");
        for (int g = 0; g < 2; g++) chk($sformatf("t2_pops%0d", g), 32'(pops[g]), 16);

        // 3: alternating ready over 8 words
        clear_stats();
        for (int i = 0; i < 8; i++) push_word(DATA_W'($urandom));
        repeat (40) begin
            @(negedge clk);
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        wait_idle(100, "t3");
        for (int g = 0; g < 2; g++) chk($sformatf("t3_pops%0d", g), 32'(pops[g]), 8);

        // 4: drain_en drops after three pops
        clear_stats();
        for (int i = 0; i < 12; i++) push_word(DATA_W'($urandom));
        for (int c = 0; c < 100 && drain_en != 2'b00; c++) begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                if (drain_en[g] && pops[g] >= 3) begin
                    drain_en[g]  = 1'b0;
                    pops_off[g]  = pops[g];
                    reads_off[g] = reads[g];
                    fq_off[g]    = fq[g].size();
                end
            end
        end
        chk("t4_stopped", 32'(drain_en), 0);
        repeat (15) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("t4_tail%0d", g), 32'((pops[g] - pops_off[g]) <= 2), 1);
            chk($sformatf("t4_noread%0d", g), 32'(reads[g]), 32'(reads_off[g]));
            chk($sformatf("t4_retained%0d", g), 32'(fq[g].size()), 32'(fq_off[g]));
        end
        drain_en = 2'b11;
        wait_idle(200, "t4");
        for (int g = 0; g < 2; g++) chk($sformatf("t4_pops%0d", g), 32'(pops[g]), 12);

        // 5: reset with words buffered and in flight
        clear_stats();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(DATA_W'($urandom));
        repeat (3) @(negedge clk);
        reset_pulse(1'b1);
        for (int g = 0; g < 2; g++) remain[g] = exp_q[g].size();
        m_ready = 1'b1;
        wait_idle(200, "t5");
        for (int g = 0; g < 2; g++) chk($sformatf("t5_cnt%0d", g), 32'(cnt_v[g]), 32'(remain[g]));

        // 6: 20 words from a fresh reset; narrow counter wraps
        reset_pulse(1'b0);
        clear_stats();
        for (int i = 0; i < 20; i++) push_word(DATA_W'($urandom));
        wait_idle(200, "t6");
        chk("t6_cnt0", 32'(cnt_v[0]), 20);
        chk("t6_cnt1", 32'(cnt_v[1]), 4);
        for (int g = 0; g < 2; g++)
            chk($sformatf("t6_span%0d", g), 32'(last_pop[g] - first_pop[g]), 32'(span(g + 1, 20)));

        // 7: random ready, drain enable and FIFO refills
        clear_stats();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            m_ready     = ($urandom_range(0, 3) != 0);
            drain_en[0] = ($urandom_range(0, 3) != 0);
            drain_en[1] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) push_word(DATA_W'($urandom));
            end
        end
        drain_en = 2'b11;
        m_ready  = 1'b1;
        wait_idle(600, "t7");
        chk("t7_cnt0", 32'(cnt_v[0]), 32'(delivered[0] % 65536));
        chk("t7_cnt1", 32'(cnt_v[1]), 32'(delivered[1] % 16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
